pipe_result_collector: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_result_collector_if.sv | 13 +
 rtl/pipe_sync_fifo.sv | 57 +++++
 rtl/pipe_result_collector.sv | 79 +++++++
 tb/tb_pipe_result_collector.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline result collector slice.
package pipe_pkg;

   localparam int N     = 10;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int ACC_W = 16;
   localparam int PTR_W = $clog2(DEPTH) + 1;

   typedef logic [N-1:0] result_t;

endpackage

// File: rtl/pipe_result_collector_if.sv
// Valid/ready result port of the collector; master drives data, slave drives ready.
import pipe_pkg::*;

interface pipe_result_collector_if #(
   parameter int N = pipe_pkg::N
);
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/pipe_sync_fifo.sv
// Small synchronous FIFO with an extra-bit pointer scheme and a registered head word.
import pipe_pkg::*;

module pipe_sync_fifo #(
   parameter int N     = pipe_pkg::N,
   parameter int DEPTH = pipe_pkg::DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [N-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW-1:0] wr_ptr_next, rd_ptr_next;
   logic [N-1:0]  head_reg;
   logic          head_load;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign dout  = head_reg;

   // push/pop arrive already qualified against full/empty by the caller.
   always_comb begin
      wr_ptr_next = wr_ptr_reg + PW'(push);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      head_load   = (empty && push) || (pop && (rd_ptr_next != wr_ptr_next));
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   // The head register keeps the last popped word visible while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         head_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         if (head_load)
            head_reg <= (rd_ptr_next == wr_ptr_reg) ? din : mem[rd_ptr_next[AW-1:0]];
      end
   end

endmodule

// File: rtl/pipe_result_collector.sv
// Tags pipeline F samples with a delayed valid, queues them and keeps count/overflow status.
// Optional running sum of accepted results is enabled by defining PIPE_COLLECT_ACC_EN.
import pipe_pkg::*;

module pipe_result_collector #(
   parameter int N     = pipe_pkg::N,
   parameter int LAT   = pipe_pkg::LAT,
   parameter int DEPTH = pipe_pkg::DEPTH,
   parameter int CNT_W = pipe_pkg::CNT_W,
   parameter int ACC_W = pipe_pkg::ACC_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [N-1:0]                f_in,
   pipe_result_collector_if.master     out_if,
   output logic [CNT_W-1:0]            count,
   output logic                        overflow,
   output logic [ACC_W-1:0]            acc_sum
);
   logic [LAT-1:0]   vd_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic             full, empty;
   logic             res_valid, do_push, do_pop, drop;

   assign res_valid = vd_reg[LAT-1];
   assign do_pop    = !empty && out_if.out_ready;
   // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
   assign do_push   = res_valid && (!full || do_pop);
   assign drop      = res_valid && !do_push;

   assign out_if.out_valid = !empty;
   assign count            = count_reg;
   assign overflow         = overflow_reg;

   pipe_sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (do_push),
      .pop   (do_pop),
      .din   (f_in),
      .dout  (out_if.out_data),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         vd_reg       <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         vd_reg[0] <= in_valid;
         for (int i = 1; i < LAT; i++)
            vd_reg[i] <= vd_reg[i-1];
         if (do_push)
            count_reg <= count_reg + CNT_W'(1);
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

`ifdef PIPE_COLLECT_ACC_EN
   logic [ACC_W-1:0] acc_reg;

   always_ff @(posedge clk) begin
      if (rst)
         acc_reg <= '0;
      else if (do_push)
         acc_reg <= acc_reg + ACC_W'(f_in);
   end

   assign acc_sum = acc_reg;
`else
   assign acc_sum = '0;
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed scoreboard bench for pipe_result_collector driven through a behavioural F pipeline.
import pipe_pkg::*;

module tb_pipe_result_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             in_valid;
   logic [N-1:0]     a, b, c, d;
   logic [N-1:0]     s1, s2, d1, d2, f_pipe;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic [ACC_W-1:0] acc_sum;

   int      checks = 0;
   int      errors = 0;
   result_t exp_q[$];

   pipe_result_collector_if #(.N(N)) out_if ();

   pipe_result_collector #(
      .N(N), .LAT(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W), .ACC_W(ACC_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .f_in     (f_pipe),
      .out_if   (out_if),
      .count    (count),
      .overflow (overflow),
      .acc_sum  (acc_sum)
   );

   // Three-register arithmetic pipeline feeding the collector (no valid of its own).
   initial begin
      s1 = '0; s2 = '0; d1 = '0; d2 = '0; f_pipe = '0;
   end
   always @(posedge clk) begin
      s1     <= a + b + c;
      d1     <= d;
      s2     <= s1 - d1;
      d2     <= d1;
      f_pipe <= N'(s2 * d2);
   end

   function automatic result_t f_model(input logic [N-1:0] fa, fb, fc, fd);
      logic [N-1:0] t;
      t = fa + fb + fc - fd;
      return N'(t * fd);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic    hs;
      result_t data;
      result_t e;
      @(negedge clk);
      hs   = out_if.out_valid && out_if.out_ready;
      data = out_if.out_data;
      @(posedge clk);
      #1;
      if (hs === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_pop observed=%0d expected=none", data);
         end else begin
            e = exp_q.pop_front();
            $display("POP data=%0d expected=%0d", data, e);
            chk("pop_data", 32'(data), 32'(e));
         end
      end
   endtask

   task automatic send(input logic [N-1:0] sa, sb, sc, sd);
      in_valid = 1'b1;
      a = sa; b = sb; c = sc; d = sd;
      exp_q.push_back(f_model(sa, sb, sc, sd));
      $display("SEND A=%0d B=%0d C=%0d D=%0d F=%0d", sa, sb, sc, sd, f_model(sa, sb, sc, sd));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         tick();
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      tick();
      chk("drain_empty", 32'(out_if.out_valid), 32'd0);
      out_if.out_ready = 1'b0;
   endtask

   task automatic do_reset();
      out_if.out_ready = 1'b0;
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      out_if.out_ready = 1'b0;

      // Reset state
      do_reset();
      chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
      chk("rst_out_data", 32'(out_if.out_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_acc", 32'(acc_sum), 32'd0);

      // Three back-to-back results, consumer always ready
      out_if.out_ready = 1'b1;
      send(10'd10, 10'd12, 10'd6, 10'd3);
      send(10'd10, 10'd10, 10'd5, 10'd3);
      send(10'd20, 10'd11, 10'd1, 10'd4);
      chk("lat_not_yet", 32'(out_if.out_valid), 32'd0);
      tick();
      chk("lat_first_valid", 32'(out_if.out_valid), 32'd1);
      chk("lat_first_data", 32'(out_if.out_data), 32'd75);
      drain();
      chk("s1_count", 32'(count), 32'd3);
      chk("s1_overflow", 32'(overflow), 32'd0);
`ifdef PIPE_COLLECT_ACC_EN
      chk("s1_acc", 32'(acc_sum), 32'd253);
`else
      chk("s1_acc", 32'(acc_sum), 32'd0);
`endif

      // Same stream held by a stalled consumer
      do_reset();
      send(10'd10, 10'd12, 10'd6, 10'd3);
      send(10'd10, 10'd10, 10'd5, 10'd3);
      send(10'd20, 10'd11, 10'd1, 10'd4);
      repeat (10) tick();
      chk("s2_hold_valid", 32'(out_if.out_valid), 32'd1);
      chk("s2_hold_data", 32'(out_if.out_data), 32'd75);
      chk("s2_count", 32'(count), 32'd3);
      drain();

      // Six results into a four-entry FIFO with no consumer
      do_reset();
      for (int i = 0; i < 6; i++)
         send(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)),
              N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
      repeat (4) tick();
      chk("s3_overflow", 32'(overflow), 32'd1);
      chk("s3_count", 32'(count), 32'd4);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      drain();
      chk("s3_overflow_sticky", 32'(overflow), 32'd1);

      // Full FIFO: pop and push land on the same edge
      do_reset();
      for (int i = 0; i < 5; i++)
         send(N'(i + 1), N'(2 * i + 3), N'(7), N'(i + 2));
      tick();
      tick();
      chk("s4_full_valid", 32'(out_if.out_valid), 32'd1);
      chk("s4_full_count", 32'(count), 32'd4);
      out_if.out_ready = 1'b1;
      tick();
      out_if.out_ready = 1'b0;
      chk("s4_overflow", 32'(overflow), 32'd0);
      chk("s4_count", 32'(count), 32'd5);
      chk("s4_queue_left", 32'(exp_q.size()), 32'd4);
      drain();

      // Reset with two results stored and two in flight
      do_reset();
      send(10'd1, 10'd2, 10'd3, 10'd1);
      send(10'd4, 10'd5, 10'd6, 10'd2);
      send(10'd7, 10'd8, 10'd9, 10'd3);
      send(10'd9, 10'd9, 10'd9, 10'd4);
      tick();
      chk("s5_stored", 32'(count), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("s5_out_valid", 32'(out_if.out_valid), 32'd0);
      chk("s5_count", 32'(count), 32'd0);
      chk("s5_overflow", 32'(overflow), 32'd0);
      chk("s5_out_data", 32'(out_if.out_data), 32'd0);
      out_if.out_ready = 1'b1;
      repeat (5) tick();
      chk("s5_no_late_push_valid", 32'(out_if.out_valid), 32'd0);
      chk("s5_no_late_push_count", 32'(count), 32'd0);
      chk("s5_acc", 32'(acc_sum), 32'd0);
      out_if.out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
